sr_latch_sequencer: RTL and testbench



---
 rtl/sr_ctrl_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 44 ++++
 rtl/sr_latch_sequencer.sv | 143 ++++++++++++++
 tb/tb_sr_latch_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sr_ctrl_pkg.sv
// Shared types and constants for the SR latch sequencer: FSM states, operation
// encoding, requester ids and the latch readback test.
package sr_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PULSE  = 2'd1,
    SETTLE = 2'd2,
    CHECK  = 2'd3
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  localparam int unsigned ID_W = 1;
  localparam logic [ID_W-1:0] ID_REQ0 = 1'b0;
  localparam logic [ID_W-1:0] ID_REQ1 = 1'b1;

  // A healthy latch shows Q equal to the requested op and Qbar its complement.
  function automatic logic readback_ok(input logic q, input logic qbar, input logic op);
    return (q == op) && (qbar == ~op);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: a lone requester wins outright, contention goes to the
// requester named by the pointer, and the pointer follows each accepted grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] grant_o
);

  logic ptr_q;
  logic ptr_d;

  // One-hot grant selection.
  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = ptr_q ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

  // The pointer moves only when the owner actually accepts a grant.
  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && (grant_o != 2'b00)) begin
      ptr_d = grant_o[1];
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sr_latch_sequencer.sv
// Owns the S/R drive of one external SR latch: arbitrates two requesters, issues
// a fixed-width pulse, lets the latch settle and verifies the Q/Qbar readback.
module sr_latch_sequencer
  import sr_ctrl_pkg::*;
#(
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic op0,
  input  logic req1,
  input  logic op1,
  output logic ack0,
  output logic ack1,
  output logic err,
  output logic busy,
  output logic s_out,
  output logic r_out,
  input  logic q_in,
  input  logic qbar_in
);

  localparam logic [CNT_W-1:0] PULSE_LOAD  = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             s_q, s_d, r_q, r_d;
  logic             ack0_q, ack0_d, ack1_q, ack1_d, err_q, err_d;
  logic [1:0]       req_s, grant_s;

  // A requester still holding req during its own ack cycle is not served twice.
  assign req_s = {req1 & ~ack1_q, req0 & ~ack0_q};

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_s),
    .advance_i (state_q == IDLE),
    .grant_o   (grant_s)
  );

  // Next-state, counter and output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    id_d    = id_q;
    s_d     = s_q;
    r_d     = r_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_s != 2'b00) begin
          id_d    = grant_s[1] ? ID_REQ1 : ID_REQ0;
          op_d    = grant_s[1] ? op1 : op0;
          cnt_d   = PULSE_LOAD;
          s_d     = (op_d == OP_SET);
          r_d     = (op_d == OP_RESET);
          state_d = PULSE;
        end else begin
          s_d = 1'b0;
          r_d = 1'b0;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          s_d     = 1'b0;
          r_d     = 1'b0;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SETTLE: begin
        s_d = 1'b0;
        r_d = 1'b0;
        if (cnt_q == '0) begin
          state_d = CHECK;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      CHECK: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        err_d   = ~readback_ok(q_in, qbar_in, op_q);
        ack0_d  = (id_q == ID_REQ0);
        ack1_d  = (id_q == ID_REQ1);
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        s_d     = 1'b0;
        r_d     = 1'b0;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset drops S/R immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      id_q    <= ID_REQ0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      id_q    <= id_d;
      s_q     <= s_d;
      r_q     <= r_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
    end
  end

  assign s_out = s_q;
  assign r_out = r_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign err   = err_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Bench for sr_latch_sequencer: two instances (default timing and a 1/3 pulse/settle
// variant) checked every cycle against a transaction-level model of each operation.
module tb_sr_latch_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] req0_v = 2'b00, op0_v = 2'b00, req1_v = 2'b00, op1_v = 2'b00;
  logic [1:0] q_v = 2'b00, qb_v = 2'b11, latch_q = 2'b00;
  logic [1:0] stuck_en = 2'b00, stuck_q = 2'b00, stuck_qb = 2'b00;
  logic [1:0] ack0_w, ack1_w, err_w, busy_w, s_w, r_w;
  int n_checks = 0;
  int n_errors = 0;
  bit rand_mode = 1'b0;
  int p_len [2] = '{2, 1};
  int s_len [2] = '{1, 3};
  logic [1:0] m_busy, m_op, m_id, m_ptr, m_ack0, m_ack1, m_err;
  int m_t [2];

  always #5 clk = ~clk;

  sr_latch_sequencer u_dut_a (
    .clk(clk), .rst(rst),
    .req0(req0_v[0]), .op0(op0_v[0]), .req1(req1_v[0]), .op1(op1_v[0]),
    .ack0(ack0_w[0]), .ack1(ack1_w[0]), .err(err_w[0]), .busy(busy_w[0]),
    .s_out(s_w[0]), .r_out(r_w[0]), .q_in(q_v[0]), .qbar_in(qb_v[0])
  );

  sr_latch_sequencer #(.PULSE_CYCLES(1), .SETTLE_CYCLES(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req0(req0_v[1]), .op0(op0_v[1]), .req1(req1_v[1]), .op1(op1_v[1]),
    .ack0(ack0_w[1]), .ack1(ack1_w[1]), .err(err_w[1]), .busy(busy_w[1]),
    .s_out(s_w[1]), .r_out(r_w[1]), .q_in(q_v[1]), .qbar_in(qb_v[1])
  );

  // Behavioural external latch, optionally forced to a faulty readback.
  always @(negedge clk) begin : latch_model
    logic nl;
    for (int d = 0; d < 2; d++) begin
      nl = s_w[d] ? 1'b1 : (r_w[d] ? 1'b0 : latch_q[d]);
      latch_q[d] <= nl;
      q_v[d]     <= stuck_en[d] ? stuck_q[d]  : nl;
      qb_v[d]    <= stuck_en[d] ? stuck_qb[d] : ~nl;
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int d);
    m_busy[d] = 1'b0; m_ptr[d] = 1'b0; m_ack0[d] = 1'b0; m_ack1[d] = 1'b0;
    m_err[d] = 1'b0; m_op[d] = 1'b0; m_id[d] = 1'b0; m_t[d] = 0;
  endtask

  // One clock edge at operation level: t counts edges since the grant edge.
  task automatic model_step(input int d);
    logic e0, e1, win, a0, a1, er;
    a0 = 1'b0; a1 = 1'b0; er = 1'b0;
    if (m_busy[d]) begin
      if (m_t[d] == p_len[d] + s_len[d]) begin
        m_busy[d] = 1'b0;
        if (m_id[d]) a1 = 1'b1; else a0 = 1'b1;
        er = !((q_v[d] == m_op[d]) && (qb_v[d] == !m_op[d]));
      end else begin
        m_t[d] = m_t[d] + 1;
      end
    end else begin
      e0 = req0_v[d] && !m_ack0[d];
      e1 = req1_v[d] && !m_ack1[d];
      if (e0 || e1) begin
        win = (e0 && e1) ? m_ptr[d] : e1;
        m_ptr[d] = win; m_id[d] = win; m_busy[d] = 1'b1; m_t[d] = 0;
        m_op[d] = win ? op1_v[d] : op0_v[d];
      end
    end
    m_ack0[d] = a0; m_ack1[d] = a1; m_err[d] = er;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) model_reset(d); else model_step(d);
      check_eq($sformatf("ack0_%0d", d), int'(ack0_w[d]), int'(m_ack0[d]));
      check_eq($sformatf("ack1_%0d", d), int'(ack1_w[d]), int'(m_ack1[d]));
      check_eq($sformatf("err_%0d", d), int'(err_w[d]), int'(m_err[d]));
      check_eq($sformatf("busy_%0d", d), int'(busy_w[d]), int'(m_busy[d]));
      check_eq($sformatf("s_%0d", d), int'(s_w[d]),
               int'(m_busy[d] && (m_t[d] < p_len[d]) && m_op[d]));
      check_eq($sformatf("r_%0d", d), int'(r_w[d]),
               int'(m_busy[d] && (m_t[d] < p_len[d]) && !m_op[d]));
      check_eq($sformatf("sr_excl_%0d", d), int'(s_w[d] & r_w[d]), 0);
      check_eq($sformatf("ack_excl_%0d", d), int'(ack0_w[d] & ack1_w[d]), 0);
      check_eq($sformatf("err_wo_ack_%0d", d), int'(err_w[d] & ~(ack0_w[d] | ack1_w[d])), 0);
      if (m_ack0[d] && req0_v[d]) begin
        if (!(rand_mode && $urandom_range(0, 3) == 0)) req0_v[d] = 1'b0;
      end else if (rand_mode && !req0_v[d] && $urandom_range(0, 2) == 0) begin
        req0_v[d] = 1'b1; op0_v[d] = 1'($urandom);
      end
      if (m_ack1[d] && req1_v[d]) begin
        if (!(rand_mode && $urandom_range(0, 3) == 0)) req1_v[d] = 1'b0;
      end else if (rand_mode && !req1_v[d] && $urandom_range(0, 2) == 0) begin
        req1_v[d] = 1'b1; op1_v[d] = 1'($urandom);
      end
    end
  endtask

  // Issue one request and measure pulse widths and the cycle the ack lands in.
  task automatic run_single(input int d, input bit which, input bit op,
                            output int lat, output int s_cnt, output int r_cnt, output int err_seen);
    lat = -1; s_cnt = 0; r_cnt = 0; err_seen = -1;
    if (which) begin req1_v[d] = 1'b1; op1_v[d] = op; end
    else begin req0_v[d] = 1'b1; op0_v[d] = op; end
    for (int k = 1; k <= 30 && lat < 0; k++) begin
      tick();
      s_cnt += int'(s_w[d]);
      r_cnt += int'(r_w[d]);
      if ((which ? ack1_w[d] : ack0_w[d]) == 1'b1) begin
        lat = k;
        err_seen = int'(err_w[d]);
      end
    end
  endtask

  task automatic run_pair(output int first, output int second);
    int got [$];
    req0_v[0] = 1'b1; op0_v[0] = 1'b1; req1_v[0] = 1'b1; op1_v[0] = 1'b0;
    for (int k = 0; k < 40 && got.size() < 2; k++) begin
      tick();
      if (ack0_w[0]) got.push_back(0);
      if (ack1_w[0]) got.push_back(1);
    end
    first  = (got.size() > 0) ? got[0] : -1;
    second = (got.size() > 1) ? got[1] : -1;
  endtask

  initial begin
    int lat, sc, rc, es, f, s2;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_s", int'(s_w[0] | s_w[1]), 0);
    check_eq("rst_busy", int'(busy_w[0] | busy_w[1]), 0);
    rst = 1'b0;
    tick();

    run_single(0, 1'b0, 1'b1, lat, sc, rc, es);
    check_eq("set_lat_a", lat, 5);
    check_eq("set_s_width_a", sc, 2);
    check_eq("set_r_width_a", rc, 0);
    check_eq("set_err_a", es, 0);
    run_single(1, 1'b0, 1'b1, lat, sc, rc, es);
    check_eq("set_lat_b", lat, 6);
    check_eq("set_s_width_b", sc, 1);
    run_single(1, 1'b1, 1'b0, lat, sc, rc, es);
    check_eq("rst_op_lat_b", lat, 6);
    check_eq("rst_op_r_width_b", rc, 1);
    check_eq("rst_op_s_width_b", sc, 0);

    run_pair(f, s2);
    check_eq("pair1_first", f, 0);
    check_eq("pair1_second", s2, 1);
    repeat (2) tick();
    run_pair(f, s2);
    check_eq("pair2_first", f, 1);
    check_eq("pair2_second", s2, 0);
    repeat (2) tick();

    stuck_en[0] = 1'b1; stuck_q[0] = 1'b0; stuck_qb[0] = 1'b1;
    run_single(0, 1'b1, 1'b1, lat, sc, rc, es);
    check_eq("fault_lat", lat, 5);
    check_eq("fault_err", es, 1);
    check_eq("fault_idle", int'(busy_w[0]), 0);
    stuck_q[0] = 1'b1; stuck_qb[0] = 1'b1;
    run_single(0, 1'b0, 1'b1, lat, sc, rc, es);
    check_eq("q_eq_qbar_err", es, 1);
    stuck_en[0] = 1'b0;
    repeat (2) tick();

    rand_mode = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if (i % 250 == 0) begin
        stuck_en[0] = ($urandom_range(0, 3) == 0);
        stuck_q[0] = 1'($urandom); stuck_qb[0] = 1'($urandom);
      end
      tick();
    end
    rand_mode = 1'b0;
    stuck_en = 2'b00;
    repeat (40) tick();

    req0_v[0] = 1'b1; op0_v[0] = 1'b0;
    tick();
    check_eq("mid_r_on", int'(r_w[0]), 1);
    #3 rst = 1'b1;
    #1;
    check_eq("mid_r_drop", int'(r_w[0]), 0);
    check_eq("mid_busy", int'(busy_w[0]), 0);
    check_eq("mid_ack", int'(ack0_w[0] | ack1_w[0]), 0);
    req0_v[0] = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (3) tick();
    run_single(0, 1'b0, 1'b0, lat, sc, rc, es);
    check_eq("reissue_lat", lat, 5);
    check_eq("reissue_r_width", rc, 2);
    check_eq("reissue_err", es, 0);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
